// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
package spi_regfile_pkg;

    // Frame decoder states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Position of the R/nW flag within the frame, counted from the first bit sent
    localparam int RNW_BIT = 0;

    // Total frame length: R/nW flag + address field + data field
    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input plus rise/fall detection
// derived from the last two synchronised samples.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   dout_p1;

    // Synchroniser chain and one-sample history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= {SYNC_STAGES{RESET_VAL}};
            dout_p1 <= RESET_VAL;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
            dout_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign dout = sync_p0[SYNC_STAGES-1];
    assign rise = dout & ~dout_p1;
    assign fall = ~dout & dout_p1;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0/mode-2 peripheral decoding fixed-length write/read frames into a
// flat register file. Define SPI_REGFILE_READBACK_EN to enable CIPO readback
// of the addressed register during the data phase of read frames.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int   DATA_W      = 8,
    parameter int   ADDR_W      = 7,
    parameter int   NUM_REGS    = 5,
    parameter int   SYNC_STAGES = 2,
    parameter logic CPOL        = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
    localparam int RNW_POS = FRAME_W - 1 - RNW_BIT;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    // Counter saturates one past a full frame so over-long frames stay detectable
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(FRAME_W + 1)) ? c : c + CNT_W'(1);
    endfunction

    logic sclk_s, sclk_rise, sclk_fall, sclk_lead;
    logic ncs_s, ncs_rise, ncs_fall;
    logic copi_s;
    logic [SYNC_STAGES-1:0] copi_sync_p0;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [FRAME_W-1:0] shreg_q, shreg_nxt;
    logic               wr_nxt, err_nxt, addr_ok;
    logic [ADDR_W-1:0]  frame_addr;
    logic [DATA_W-1:0]  frame_data;
    logic [NUM_REGS*DATA_W-1:0] regs_q;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
        .clk(clk), .rst_n(rst_n), .din(ncs),
        .dout(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    // COPI only needs the synchroniser; its edges carry no meaning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) copi_sync_p0 <= '0;
        else        copi_sync_p0 <= {copi_sync_p0[SYNC_STAGES-2:0], copi};
    end
    assign copi_s = copi_sync_p0[SYNC_STAGES-1];

    // Leading edge moves SCLK away from its idle level
    assign sclk_lead  = (sclk_rise | sclk_fall) & (sclk_s != CPOL);

    assign frame_addr = shreg_q[DATA_W +: ADDR_W];
    assign frame_data = shreg_q[DATA_W-1:0];
    assign addr_ok    = 32'(frame_addr) < NUM_REGS;

    // Frame decoder state, bit counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            shreg_q <= shreg_nxt;
        end
    end

    // Next-state logic; CHECK also decides commit or rejection of the frame
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        shreg_nxt = shreg_q;
        wr_nxt    = 1'b0;
        err_nxt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_nxt = CHECK;
                end else if (sclk_lead && !ncs_s) begin
                    shreg_nxt = {shreg_q[FRAME_W-2:0], copi_s};
                    cnt_nxt   = sat_inc(cnt_q);
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                if ((cnt_q != CNT_W'(FRAME_W)) || !addr_ok) begin
                    err_nxt = 1'b1;
                end else if (shreg_q[RNW_POS]) begin
                    wr_nxt = 1'b1;
                end
                // A chip-select fall landing in this cycle starts the next frame directly
                if (ncs_fall) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register file and write/error pulses, committed on the edge leaving CHECK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q    <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= wr_nxt;
            frame_err <= err_nxt;
            if (wr_nxt) begin
                wr_addr <= frame_addr;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (frame_addr == ADDR_W'(k)) regs_q[k*DATA_W +: DATA_W] <= frame_data;
                end
            end
        end
    end

    assign regs_o = regs_q;

`ifdef SPI_REGFILE_READBACK_EN
    logic              sclk_trail;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] tx_q;

    assign sclk_trail = (sclk_rise | sclk_fall) & (sclk_s == CPOL);

    // Addressed register for readback; out-of-range addresses read as zero
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (shreg_q[ADDR_W-1:0] == ADDR_W'(k)) rd_word = regs_q[k*DATA_W +: DATA_W];
        end
    end

    // Output shifter: load after the last address bit of a read, then shift per trailing edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
        end else if (state_q == IDLE) begin
            tx_q <= '0;
        end else if (state_q == SHIFT && sclk_trail) begin
            if (cnt_q == CNT_W'(1 + ADDR_W) && !shreg_q[ADDR_W]) tx_q <= rd_word;
            else                                                 tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        end
    end

    assign cipo = ~ncs_s & tx_q[DATA_W-1];
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: a CPOL=0 and a CPOL=1 instance
// receive the same frames (sclk of the second is the inverse of the first).
`timescale 1ns/1ps
module tb_spi_regfile_peripheral;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;
    localparam int NUM_REGS = 5;
    localparam int RW       = NUM_REGS * DATA_W;
    localparam int HALF     = 80;   // half SCLK period: 8 clk cycles

    logic clk = 1'b0, rst_n = 1'b1, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic sclk_b;
    logic cipo, cipo_b, wr_strobe, wr_strobe_b, frame_err, frame_err_b;
    logic [RW-1:0]     regs_o, regs_o_b;
    logic [ADDR_W-1:0] wr_addr, wr_addr_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    int n_err    = 0;
    logic [ADDR_W-1:0] addr_log[$];

    logic [DATA_W-1:0] rx_a, rx_b, exp_rb;
    int s0, e0;

    assign sclk_b = ~sclk;
    always #5 clk = ~clk;

    spi_regfile_peripheral #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
                             .SYNC_STAGES(2), .CPOL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .regs_o(regs_o), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .frame_err(frame_err)
    );

    spi_regfile_peripheral #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
                             .SYNC_STAGES(2), .CPOL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_b), .copi(copi), .ncs(ncs),
        .cipo(cipo_b), .regs_o(regs_o_b), .wr_strobe(wr_strobe_b),
        .wr_addr(wr_addr_b), .frame_err(frame_err_b)
    );

    // Pulse monitor on the CPOL=0 instance, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_strobe) begin
            n_strobe++;
            addr_log.push_back(wr_addr);
        end
        if (frame_err) n_err++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Clock out nbits of 'bits' MSB first; capture CIPO before each data-phase leading edge
    task automatic shift_bits(input int nbits, input logic [31:0] bits,
                              output logic [DATA_W-1:0] ra, output logic [DATA_W-1:0] rb);
        ra = '0;
        rb = '0;
        for (int i = 0; i < nbits; i++) begin
            copi = bits[nbits-1-i];
            #HALF;
            if (i > ADDR_W && i < 1 + ADDR_W + DATA_W) begin
                ra = {ra[DATA_W-2:0], cipo};
                rb = {rb[DATA_W-2:0], cipo_b};
            end
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    // Full frame, then nCS high for two SCLK periods
    task automatic spi_frame(input int nbits, input logic [31:0] bits,
                             output logic [DATA_W-1:0] ra, output logic [DATA_W-1:0] rb);
        ncs = 1'b0;
        #HALF;
        shift_bits(nbits, bits, ra, rb);
        #HALF;
        ncs  = 1'b1;
        copi = 1'b0;
        #(4*HALF);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #30;
        check("rst_regs", 64'(regs_o), 64'h0);
        check("rst_strobe", 64'(wr_strobe), 64'h0);
        check("rst_addr", 64'(wr_addr), 64'h0);
        check("rst_err", 64'(frame_err), 64'h0);
        check("rst_cipo", 64'(cipo), 64'h0);
        #1 rst_n = 1'b1;
        #50;

        // Valid write addr2 = 0xA5
        s0 = n_strobe; e0 = n_err;
        spi_frame(16, 32'h82A5, rx_a, rx_b);
        check("wr2_regs", 64'(regs_o), 64'h00_00_A5_00_00);
        check("wr2_regs_cpol1", 64'(regs_o_b), 64'h00_00_A5_00_00);
        check("wr2_strobes", 64'(n_strobe - s0), 64'd1);
        check("wr2_addr", 64'(wr_addr), 64'd2);
        check("wr2_err", 64'(n_err - e0), 64'd0);

        // Out-of-range address
        s0 = n_strobe; e0 = n_err;
        spi_frame(16, 32'h8577, rx_a, rx_b);
        check("bad_addr_err", 64'(n_err - e0), 64'd1);
        check("bad_addr_strobes", 64'(n_strobe - s0), 64'd0);
        check("bad_addr_regs", 64'(regs_o), 64'h00_00_A5_00_00);

        // Short (10-bit) and long (17-bit) frames
        s0 = n_strobe; e0 = n_err;
        spi_frame(10, 32'h207, rx_a, rx_b);
        check("short_err", 64'(n_err - e0), 64'd1);
        check("short_regs", 64'(regs_o), 64'h00_00_A5_00_00);
        e0 = n_err;
        spi_frame(17, 32'h10267, rx_a, rx_b);
        check("long_err", 64'(n_err - e0), 64'd1);
        check("long_regs", 64'(regs_o), 64'h00_00_A5_00_00);
        check("len_strobes", 64'(n_strobe - s0), 64'd0);

        // Back-to-back writes addr0=0x12, addr4=0xFF
        s0 = n_strobe; e0 = n_err;
        addr_log.delete();
        spi_frame(16, 32'h8012, rx_a, rx_b);
        spi_frame(16, 32'h84FF, rx_a, rx_b);
        check("b2b_strobes", 64'(n_strobe - s0), 64'd2);
        check("b2b_first", 64'(addr_log.size() > 0 ? addr_log[0] : 7'h7F), 64'd0);
        check("b2b_second", 64'(addr_log.size() > 1 ? addr_log[1] : 7'h7F), 64'd4);
        check("b2b_regs", 64'(regs_o), 64'hFF_00_A5_00_12);
        check("b2b_regs_cpol1", 64'(regs_o_b), 64'hFF_00_A5_00_12);
        check("b2b_err", 64'(n_err - e0), 64'd0);

        // Write addr3=0x3C, then read it back
        spi_frame(16, 32'h833C, rx_a, rx_b);
        check("wr3_regs", 64'(regs_o), 64'hFF_3C_A5_00_12);
`ifdef SPI_REGFILE_READBACK_EN
        exp_rb = 8'h3C;
`else
        exp_rb = 8'h00;
`endif
        s0 = n_strobe; e0 = n_err;
        spi_frame(16, 32'h0300, rx_a, rx_b);
        check("rd3_cipo", 64'(rx_a), 64'(exp_rb));
        check("rd3_cipo_cpol1", 64'(rx_b), 64'(exp_rb));
        check("rd3_strobes", 64'(n_strobe - s0), 64'd0);
        check("rd3_err", 64'(n_err - e0), 64'd0);
        check("rd3_regs", 64'(regs_o), 64'hFF_3C_A5_00_12);

        // Read of an invalid address: zeros and an error pulse
        e0 = n_err;
        spi_frame(16, 32'h0600, rx_a, rx_b);
        check("rd6_cipo", 64'(rx_a), 64'h0);
        check("rd6_err", 64'(n_err - e0), 64'd1);

        // Reset mid-frame after 8 bits of a write
        ncs = 1'b0;
        #HALF;
        shift_bits(8, 32'h81, rx_a, rx_b);
        rst_n = 1'b0;
        #30;
        check("midrst_regs", 64'(regs_o), 64'h0);
        check("midrst_regs_cpol1", 64'(regs_o_b), 64'h0);
        check("midrst_strobe", 64'(wr_strobe), 64'h0);
        check("midrst_addr", 64'(wr_addr), 64'h0);
        check("midrst_err", 64'(frame_err), 64'h0);
        check("midrst_cipo", 64'(cipo), 64'h0);
        ncs = 1'b1;
        #20;
        rst_n = 1'b1;
        #(2*HALF);

        s0 = n_strobe; e0 = n_err;
        spi_frame(16, 32'h815A, rx_a, rx_b);
        check("postrst_regs", 64'(regs_o), 64'h00_00_00_5A_00);
        check("postrst_strobes", 64'(n_strobe - s0), 64'd1);
        check("postrst_addr", 64'(wr_addr), 64'd1);
        check("postrst_err", 64'(n_err - e0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_regfile_peripheral.md
Name: spi_regfile_peripheral

Overview:
- Parametrised SPI mode-0/mode-2 peripheral that decodes fixed-length write/read frames into a register file of NUM_REGS x DATA_W registers.
- Oversamples SCLK/COPI/nCS in the clk domain through synchronisers.
- Drives the register file as a flat bus to downstream consumers (PWM, control).
- Adds addressable writes, frame-length checking, error flagging and optional CIPO readback.

Parameters:
- DATA_W, 8: register and data-field width.
- ADDR_W, 7: address-field width.
- NUM_REGS, 5: implemented registers; addresses 0..NUM_REGS-1 are valid.
- SYNC_STAGES, 2: synchroniser depth for sclk/copi/ncs (min 2).
- CPOL, 0: SCLK idle level. Leading edge samples, trailing edge launches (CPHA=0).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock from controller (async)
- copi  in  1  controller-out data (async)
- ncs  in  1  chip select, active low (async)
- cipo  out  1  peripheral-out data
- regs_o  out  NUM_REGS*DATA_W  register file, reg k at [k*DATA_W +: DATA_W]
- wr_strobe  out  1  one-clk pulse on committed write
- wr_addr  out  ADDR_W  address of last committed write
- frame_err  out  1  one-clk pulse on rejected frame

Behaviour:
- Reset: async on rst_n low. regs_o=0, wr_strobe=0, wr_addr=0, frame_err=0, cipo=0. Bit counter, shift register and state are cleared; synchronisers are cleared to idle (sclk=CPOL, ncs=1).
- Constraint: f_clk >= 8 x f_sclk. Edges are detected from the last two synchronised sclk samples.
- Frame format: FRAME_W = 1+ADDR_W+DATA_W bits, MSB first. Bit0 is R/nW (1 = write), then the address, then the data.
- States:
  - IDLE: ncs_s high. Wait for the ncs_s falling edge, then go to SHIFT with counter=0.
  - SHIFT: on each leading edge, shift copi_s into the shift register and increment the counter, saturating at FRAME_W+1. A rising edge on ncs_s goes to CHECK.
  - CHECK: one cycle, then back to IDLE.
- CHECK rules, decided in the same cycle:
  - counter != FRAME_W: discard the frame, frame_err=1.
  - Address >= NUM_REGS: discard the frame, frame_err=1.
  - Otherwise, if write: update the register, wr_strobe=1, wr_addr=address.
  - Otherwise, read: no state change, no pulse.
- Commit latency: regs_o updates on the clk edge after CHECK. Total latency is SYNC_STAGES+2 clk cycles after the ncs rising pin edge.
- Mid-frame nCS rise always ends the frame. A short frame is never committed.
- SCLK edges while ncs_s is high are ignored.
- Extra SCLK edges beyond FRAME_W make counter=FRAME_W+1, so the frame gets frame_err.
- Only one frame is in flight at a time. A new ncs fall arriving during CHECK is honoured on the next cycle.
- Reset asserted mid-frame aborts the frame with no commit.

Optional Feature:
- Macro SPI_REGFILE_READBACK_EN.
- Defined:
  - On the trailing edge after the last address bit of a read frame, load regs_o[address] into the output shift register and drive its MSB on cipo.
  - Shift out one bit per subsequent trailing edge.
  - An invalid address returns all zeros.
  - cipo=0 when ncs_s is high.
- Undefined: cipo is tied 0. Read frames are still length/address checked but have no other effect.

Decomposition:
- Package spi_regfile_pkg holds:
  - FRAME_W derivation function
  - state enum: IDLE, SHIFT, CHECK
  - the R/nW bit-position constant
- One sub-module, spi_sync_edge: an SYNC_STAGES synchroniser plus rise/fall detect, instantiated for sclk and ncs. copi uses the synchroniser only.

Test Plan:
- Write frame 1,addr=2,data=0xA5 (16 bits) -> regs_o[2]=0xA5, wr_strobe one pulse, wr_addr=2, all other regs 0.
- Write addr=5 with NUM_REGS=5 -> frame_err pulse, regs_o unchanged, no wr_strobe.
- 10-bit frame then ncs rise; separately a 17-bit frame -> frame_err pulse in each case, no register change.
- Back-to-back writes addr0=0x12 then addr4=0xFF, with ncs high for 2 sclk periods between -> both committed in order, two wr_strobe pulses.
- Reset asserted after 8 bits of a write -> all outputs 0; the next full write to addr1 commits normally.
- READBACK_EN: write addr3=0x3C, then read addr3 -> cipo carries 0x3C MSB-first during the data phase. Repeat with CPOL=1.
